// File: rtl/if_fetch_stage_pkg.sv
// Shared CPU definitions for the instruction fetch stage.
package if_fetch_stage_pkg;

    localparam logic [31:0] PC_RESET_VECTOR = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifbuf_entry_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: instruction memory handshake, redirect input and IF/ID output.
interface if_fetch_stage_if;

    logic        Redirect_Valid;
    logic [31:0] Redirect_PC;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        IF_Valid;
    logic [31:0] IF_Instr;
    logic [31:0] IF_PC;
    logic [31:0] IF_PCAdd1;
    logic        IF_IDWr;

    // Fetch stage side
    modport master (
        input  Redirect_Valid, Redirect_PC, inst_addr_ok, inst_data_ok, inst_rdata, IF_IDWr,
        output inst_req, inst_addr, IF_Valid, IF_Instr, IF_PC, IF_PCAdd1
    );

    // Memory / pipeline side
    modport slave (
        output Redirect_Valid, Redirect_PC, inst_addr_ok, inst_data_ok, inst_rdata, IF_IDWr,
        input  inst_req, inst_addr, IF_Valid, IF_Instr, IF_PC, IF_PCAdd1
    );

endinterface

// File: rtl/if_inst_fifo.sv
// Two-entry instruction buffer between fetch and decode; head is entry 0.
module if_inst_fifo
    import if_fetch_stage_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  ifbuf_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output ifbuf_entry_t head_o
);

    ifbuf_entry_t entry0_q, entry0_d;
    ifbuf_entry_t entry1_q, entry1_d;
    logic [1:0]   count_q, count_d;
    logic         pop_eff;

    assign pop_eff = pop_i && (count_q != 2'd0);

    // Next-state for entries and count; flush wins over push/pop.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        if (flush_i) begin
            entry0_d = '0;
            entry1_d = '0;
            count_d  = 2'd0;
        end else begin
            case ({push_i, pop_eff})
                2'b10: begin
                    if (count_q == 2'd0) entry0_d = push_data_i;
                    else                 entry1_d = push_data_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    entry0_d = entry1_q;
                    entry1_d = '0;
                    count_d  = count_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (count_q == 2'd2) begin
                        entry0_d = entry1_q;
                        entry1_d = push_data_i;
                    end else begin
                        entry0_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = (count_q != 2'd0) ? entry0_q : '0;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: one outstanding request, 2-entry buffer, redirect with stale drop.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    if_fetch_stage_if.master   fetch_io
);

    fetch_state_t state_q;
    logic [31:0]  fpc_q;
    logic [31:0]  req_pc_q;     // PC of the request currently in flight
    logic [31:0]  hold_addr_q;  // address kept on the bus after a redirect before addr_ok
    logic         hold_q;
    logic         stale_q;

    logic         redirect;
    logic         push;
    logic         pop;
    logic [1:0]   count;
    logic [31:0]  inst_addr;
    ifbuf_entry_t head;
    ifbuf_entry_t push_entry;

    assign redirect   = fetch_io.Redirect_Valid;
    assign push       = (state_q == WAIT) && fetch_io.inst_data_ok && !stale_q && !redirect;
    assign pop        = fetch_io.IF_IDWr && (count != 2'd0) && !redirect;
    assign push_entry = '{pc: req_pc_q, instr: fetch_io.inst_rdata};
    assign inst_addr  = hold_q ? hold_addr_q : fpc_q;

    if_inst_fifo u_fifo (
        .clk_i      (clk),
        .rst_ni     (rst),
        .push_i     (push),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .flush_i    (redirect),
        .count_o    (count),
        .head_o     (head)
    );

    // Fetch FSM together with PC, in-flight PC and stale tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= REQ;
            fpc_q       <= PC_RESET_VECTOR;
            req_pc_q    <= '0;
            hold_addr_q <= '0;
            hold_q      <= 1'b0;
            stale_q     <= 1'b0;
        end else begin
            if (redirect) fpc_q <= fetch_io.Redirect_PC;
            unique case (state_q)
                REQ: begin
                    if (fetch_io.inst_addr_ok) begin
                        state_q  <= WAIT;
                        hold_q   <= 1'b0;
                        req_pc_q <= inst_addr;
                        // A held address was already replaced in fpc_q; do not advance past it.
                        if (!redirect && !hold_q) fpc_q <= fpc_q + 32'd4;
                        if (redirect) stale_q <= 1'b1;
                    end else if (redirect) begin
                        stale_q <= 1'b1;
                        if (!hold_q) begin
                            hold_q      <= 1'b1;
                            hold_addr_q <= fpc_q;
                        end
                    end
                end
                WAIT: begin
                    if (fetch_io.inst_data_ok) begin
                        stale_q <= 1'b0;
                        state_q <= stale_q ? REQ : IDLE;
                    end else if (redirect) begin
                        stale_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (redirect || (count != 2'd2) || pop) state_q <= REQ;
                end
                default: state_q <= REQ;
            endcase
        end
    end

    assign fetch_io.inst_req  = (state_q == REQ);
    assign fetch_io.inst_addr = inst_addr;
    assign fetch_io.IF_Valid  = (count != 2'd0);
    assign fetch_io.IF_Instr  = head.instr;
    assign fetch_io.IF_PC     = head.pc;
    assign fetch_io.IF_PCAdd1 = (count != 2'd0) ? (head.pc + 32'd4) : 32'd0;

endmodule
